// File: rtl/mac_pkg.sv
// mac_pkg: shared width default, mode encoding and saturating width reduction for the MAC element
package mac_pkg;
  localparam int MAC_WIDTH = 8;
  typedef enum logic {MODE_COMPUTE, MODE_LOAD} mode_e;
  function automatic logic [63:0] sat_reduce(input logic signed [64:0] value, input int width, input logic sgn);
    logic signed [64:0] hi, lo;
    hi = sgn ? (65'sd1 <<< (width - 1)) - 65'sd1 : (65'sd1 <<< width) - 65'sd1;
    lo = sgn ? -(65'sd1 <<< (width - 1)) : 65'sd0;
    return value > hi ? 64'(hi) : value < lo ? 64'(lo) : 64'(value);
  endfunction
endpackage

// File: rtl/mac_arith.sv
// mac_arith: combinational psum + weight*feature with wrap or clamp down to WIDTH bits
module mac_arith
  import mac_pkg::*;
#(
  parameter int WIDTH    = MAC_WIDTH,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] weight,
  input  logic [WIDTH-1:0] feature,
  input  logic [WIDTH-1:0] psum,
  output logic [WIDTH-1:0] sum
);
  localparam int SW = 2 * WIDTH + 1;
  logic signed [SW-1:0] w_x, f_x, p_x, acc;
  assign w_x = {{(SW - WIDTH){SIGNED != 0 && weight[WIDTH-1]}}, weight};
  assign f_x = {{(SW - WIDTH){SIGNED != 0 && feature[WIDTH-1]}}, feature};
  assign p_x = {{(SW - WIDTH){SIGNED != 0 && psum[WIDTH-1]}}, psum};
  assign acc = p_x + w_x * f_x;
  assign sum = SATURATE != 0 ? WIDTH'(sat_reduce(65'(acc), WIDTH, SIGNED != 0)) : WIDTH'(acc);
endmodule

// File: rtl/mac_pe.sv
// mac_pe: weight-stationary MAC element with weight shift chain through psum_out
module mac_pe
  import mac_pkg::*;
#(
  parameter int WIDTH    = MAC_WIDTH,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ctrl_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] weight_in,
  input  logic [WIDTH-1:0] feature_in,
  input  logic [WIDTH-1:0] psum_in,
  output logic [WIDTH-1:0] psum_out,
  output logic [WIDTH-1:0] feature_out,
  output logic             valid_out
);
  logic [WIDTH-1:0] weight_reg, sum;
  mode_e mode;
  assign mode = ctrl_in ? MODE_LOAD : MODE_COMPUTE;
  mac_arith #(.WIDTH(WIDTH), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_arith (
    .weight (weight_reg),
    .feature(feature_in),
    .psum   (psum_in),
    .sum    (sum)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      weight_reg  <= '0;
      psum_out    <= '0;
      feature_out <= '0;
      valid_out   <= 1'b0;
    end else begin
      valid_out   <= mode == MODE_COMPUTE && valid_in;
      feature_out <= (mode == MODE_LOAD || valid_in) ? feature_in : feature_out;
      if (mode == MODE_LOAD) begin
        weight_reg <= weight_in;
        psum_out   <= weight_reg;
      end else if (valid_in) begin
        psum_out <= sum;
      end
    end
  end
endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: random and directed checks of four mac_pe configurations against an integer reference model
module tb_mac_pe;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1, ctrl_in = 1'b0, valid_in = 1'b0;
  logic [7:0] weight_in = '0, feature_in = '0, psum_in = '0;
  logic [7:0] psum_o [4];
  logic [7:0] feat_o [4];
  logic [7:0] wreg [4];
  logic       val_o [4];
  logic [7:0] mw [4];
  logic [7:0] mp [4];
  logic [7:0] mf [4];
  logic       mv [4];
  int n_chk = 0, n_pass = 0;
  always #5 clk_in = ~clk_in;
  mac_pe #(.WIDTH(8), .SIGNED(0), .SATURATE(0)) u0 (.clk_in(clk_in), .rst_in(rst_in), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .weight_in(weight_in), .feature_in(feature_in), .psum_in(psum_in), .psum_out(psum_o[0]), .feature_out(feat_o[0]), .valid_out(val_o[0]));
  mac_pe #(.WIDTH(8), .SIGNED(0), .SATURATE(1)) u1 (.clk_in(clk_in), .rst_in(rst_in), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .weight_in(weight_in), .feature_in(feature_in), .psum_in(psum_in), .psum_out(psum_o[1]), .feature_out(feat_o[1]), .valid_out(val_o[1]));
  mac_pe #(.WIDTH(8), .SIGNED(1), .SATURATE(1)) u2 (.clk_in(clk_in), .rst_in(rst_in), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .weight_in(weight_in), .feature_in(feature_in), .psum_in(psum_in), .psum_out(psum_o[2]), .feature_out(feat_o[2]), .valid_out(val_o[2]));
  mac_pe #(.WIDTH(8), .SIGNED(1), .SATURATE(0)) u3 (.clk_in(clk_in), .rst_in(rst_in), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .weight_in(weight_in), .feature_in(feature_in), .psum_in(psum_in), .psum_out(psum_o[3]), .feature_out(feat_o[3]), .valid_out(val_o[3]));
  assign wreg[0] = u0.weight_reg;
  assign wreg[1] = u1.weight_reg;
  assign wreg[2] = u2.weight_reg;
  assign wreg[3] = u3.weight_reg;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  function automatic logic [7:0] ref_sum(input int cfg, input logic [7:0] w, input logic [7:0] f, input logic [7:0] p);
    bit sgn, sat;
    int a, b, c, s;
    sgn = cfg >= 2;
    sat = cfg == 1 || cfg == 2;
    a = (sgn && w[7]) ? int'(w) - 256 : int'(w);
    b = (sgn && f[7]) ? int'(f) - 256 : int'(f);
    c = (sgn && p[7]) ? int'(p) - 256 : int'(p);
    s = c + a * b;
    if (sat) s = sgn ? (s > 127 ? 127 : s < -128 ? -128 : s) : (s > 255 ? 255 : s);
    return 8'(s);
  endfunction
  task automatic step(input logic r, input logic c, input logic v, input logic [7:0] w, input logic [7:0] f, input logic [7:0] p);
    rst_in = r; ctrl_in = c; valid_in = v; weight_in = w; feature_in = f; psum_in = p;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        mw[i] = 0; mp[i] = 0; mf[i] = 0; mv[i] = 0;
      end else if (c) begin
        mp[i] = mw[i]; mw[i] = w; mf[i] = f; mv[i] = 0;
      end else if (v) begin
        mp[i] = ref_sum(i, mw[i], f, p); mf[i] = f; mv[i] = 1;
      end else mv[i] = 0;
    end
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("psum_out[%0d]", i), 32'(psum_o[i]), 32'(mp[i]));
      check($sformatf("feature_out[%0d]", i), 32'(feat_o[i]), 32'(mf[i]));
      check($sformatf("valid_out[%0d]", i), 32'(val_o[i]), 32'(mv[i]));
      check($sformatf("weight_reg[%0d]", i), 32'(wreg[i]), 32'(mw[i]));
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) step(1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    check("reset_psum", 32'(psum_o[0]), 32'h0);
    check("reset_valid", 32'(val_o[2]), 32'h0);
    step(0, 1, 0, 8'h03, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h01, 8'h11);
    check("load_compute_psum", 32'(psum_o[0]), 32'h14);
    check("load_compute_feat", 32'(feat_o[0]), 32'h01);
    step(0, 1, 0, 8'h05, 8'h00, 8'h00);
    step(0, 1, 1, 8'h09, 8'h00, 8'h00);
    check("shift_psum", 32'(psum_o[0]), 32'h05);
    check("shift_weight", 32'(wreg[0]), 32'h09);
    check("shift_valid", 32'(val_o[0]), 32'h0);
    step(0, 1, 0, 8'hFF, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h02, 8'h05);
    check("wrap_psum", 32'(psum_o[0]), 32'h03);
    check("sat_psum", 32'(psum_o[1]), 32'hFF);
    step(0, 1, 0, 8'h80, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h02, 8'h00);
    check("signed_min_clamp", 32'(psum_o[2]), 32'h80);
    check("signed_wrap", 32'(psum_o[3]), 32'h00);
    step(0, 0, 1, 8'h00, 8'hFF, 8'h00);
    check("signed_max_clamp", 32'(psum_o[2]), 32'h7F);
    step(1, 1, 1, 8'h55, 8'h12, 8'h34);
    check("reset_over_load", 32'(wreg[0]), 32'h0);
    step(0, 1, 0, 8'h07, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h03, 8'h01);
    step(0, 0, 0, 8'h00, 8'h44, 8'h22);
    check("hold_psum", 32'(psum_o[0]), 32'h16);
    check("hold_valid", 32'(val_o[0]), 32'h0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom), 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
